bcd_seven_seg_scan: RTL



---
 rtl/bcd_seven_seg_scan.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bcd_seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Latches BCD hundreds/tens/ones on load and scans them with blanking.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      capture hundreds/tens/ones into the display registers
//   hundreds  BCD hundreds digit
//   tens      BCD tens digit
//   ones      BCD ones digit
//   an        active-low anodes: [0]=ones [1]=tens [2]=hundreds [3]=dark
//   seg       active-low segments {g,f,e,d,c,b,a}
//   dp        active-low decimal point, always off
module bcd_seven_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_NONE = 4'b1111;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    r_d_h;
  logic [3:0]    r_d_t;
  logic [3:0]    r_d_o;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_slot_nxt;
  logic          w_h_zero;
  logic          w_t_zero;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Refresh counter and slot sequencer
  assign w_wrap = (r_cnt == CNT_MAX);

  always_comb begin
    w_cnt_nxt  = r_cnt + CW'(1);
    w_slot_nxt = r_slot;
    if (w_wrap) begin
      w_cnt_nxt  = '0;
      w_slot_nxt = r_slot + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= 2'd0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_slot <= w_slot_nxt;
    end
  end

  // Display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_h <= 4'd0;
      r_d_t <= 4'd0;
      r_d_o <= 4'd0;
    end else if (load) begin
      r_d_h <= hundreds;
      r_d_t <= tens;
      r_d_o <= ones;
    end
  end

  // Invalid codes are non-zero, so a dash is never blanked
  assign w_h_zero = (r_d_h == 4'd0);
  assign w_t_zero = (r_d_t == 4'd0);

  always_comb begin
    w_an_nxt  = AN_NONE;
    w_seg_nxt = SEG_OFF;
    case (r_slot)
      2'd0: begin
        w_an_nxt  = AN_ONES;
        w_seg_nxt = seg_decode(r_d_o);
      end
      2'd1: begin
        w_an_nxt = AN_TENS;
        if (!(w_h_zero && w_t_zero))
          w_seg_nxt = seg_decode(r_d_t);
      end
      2'd2: begin
        w_an_nxt = AN_HUND;
        if (!w_h_zero)
          w_seg_nxt = seg_decode(r_d_h);
      end
      default: begin
        w_an_nxt  = AN_NONE;
        w_seg_nxt = SEG_OFF;
      end
    endcase
  end

  // One register stage keeps an/seg changing together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_NONE;
      r_seg <= SEG_OFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule
